// File: rtl/control_alu_mdu.sv
`default_nettype none
// ============================================================================
// control_alu_mdu : EX-stage ALU decode plus iterative multiply/divide unit
// Rev 1.0
// ============================================================================
module control_alu_mdu #(
  parameter int DATA_W       = 32,
  parameter int BITS_ALU     = 6,
  parameter int BITS_ALU_CTL = 2,
  parameter int ALU_OP       = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [BITS_ALU-1:0]     i_funct,
  input  logic [BITS_ALU-1:0]     i_opcode,
  input  logic [BITS_ALU_CTL-1:0] i_alu_op,
  input  logic [DATA_W-1:0]       i_rs_data,
  input  logic [DATA_W-1:0]       i_rt_data,
  output logic [ALU_OP-1:0]       o_alu_op,
  output logic                    o_shamt,
  output logic                    o_stall,
  output logic [DATA_W-1:0]       o_hilo_data
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  localparam logic [BITS_ALU_CTL-1:0] c_CLS_ADD = BITS_ALU_CTL'(2'b00);
  localparam logic [BITS_ALU_CTL-1:0] c_CLS_SUB = BITS_ALU_CTL'(2'b01);
  localparam logic [BITS_ALU_CTL-1:0] c_CLS_R   = BITS_ALU_CTL'(2'b10);

  localparam logic [ALU_OP-1:0] c_OP_ADD  = ALU_OP'(6'b100000);
  localparam logic [ALU_OP-1:0] c_OP_SUB  = ALU_OP'(6'b100010);
  localparam logic [ALU_OP-1:0] c_OP_BADR = ALU_OP'(6'b111110);
  localparam logic [ALU_OP-1:0] c_OP_BADI = ALU_OP'(6'b111101);
  localparam logic [ALU_OP-1:0] c_OP_IDLE = ALU_OP'(6'b111111);

  localparam logic [BITS_ALU-1:0] c_F_SLL   = BITS_ALU'(6'b000000);
  localparam logic [BITS_ALU-1:0] c_F_SRL   = BITS_ALU'(6'b000010);
  localparam logic [BITS_ALU-1:0] c_F_SRA   = BITS_ALU'(6'b000011);
  localparam logic [BITS_ALU-1:0] c_F_SLLV  = BITS_ALU'(6'b000100);
  localparam logic [BITS_ALU-1:0] c_F_SRLV  = BITS_ALU'(6'b000110);
  localparam logic [BITS_ALU-1:0] c_F_SRAV  = BITS_ALU'(6'b000111);
  localparam logic [BITS_ALU-1:0] c_F_MFHI  = BITS_ALU'(6'b010000);
  localparam logic [BITS_ALU-1:0] c_F_MTHI  = BITS_ALU'(6'b010001);
  localparam logic [BITS_ALU-1:0] c_F_MFLO  = BITS_ALU'(6'b010010);
  localparam logic [BITS_ALU-1:0] c_F_MTLO  = BITS_ALU'(6'b010011);
  localparam logic [BITS_ALU-1:0] c_F_MULT  = BITS_ALU'(6'b011000);
  localparam logic [BITS_ALU-1:0] c_F_MULTU = BITS_ALU'(6'b011001);
  localparam logic [BITS_ALU-1:0] c_F_DIV   = BITS_ALU'(6'b011010);
  localparam logic [BITS_ALU-1:0] c_F_DIVU  = BITS_ALU'(6'b011011);
  localparam logic [BITS_ALU-1:0] c_F_ADD   = BITS_ALU'(6'b100000);
  localparam logic [BITS_ALU-1:0] c_F_ADDU  = BITS_ALU'(6'b100001);
  localparam logic [BITS_ALU-1:0] c_F_SUB   = BITS_ALU'(6'b100010);
  localparam logic [BITS_ALU-1:0] c_F_SUBU  = BITS_ALU'(6'b100011);
  localparam logic [BITS_ALU-1:0] c_F_AND   = BITS_ALU'(6'b100100);
  localparam logic [BITS_ALU-1:0] c_F_OR    = BITS_ALU'(6'b100101);
  localparam logic [BITS_ALU-1:0] c_F_XOR   = BITS_ALU'(6'b100110);
  localparam logic [BITS_ALU-1:0] c_F_NOR   = BITS_ALU'(6'b100111);
  localparam logic [BITS_ALU-1:0] c_F_SLT   = BITS_ALU'(6'b101010);

  localparam logic [BITS_ALU-1:0] c_O_SLTI  = BITS_ALU'(6'b001010);
  localparam logic [BITS_ALU-1:0] c_O_ANDI  = BITS_ALU'(6'b001100);
  localparam logic [BITS_ALU-1:0] c_O_ORI   = BITS_ALU'(6'b001101);
  localparam logic [BITS_ALU-1:0] c_O_XORI  = BITS_ALU'(6'b001110);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [DATA_W-1:0]   r_acc, r_q, r_b;
  logic                r_neg_q, r_neg_r, r_dz;
  logic [ALU_OP-1:0]   r_alu_op;
  logic                r_shamt;

  logic [ALU_OP-1:0]   w_alu_op;
  logic                w_shamt;
  logic                w_rclass, w_idle, w_last;
  logic                w_start, w_mthi, w_mtlo, w_signed;
  logic [DATA_W-1:0]   w_rs_mag, w_rt_mag;
  logic [DATA_W:0]     w_add;
  logic [2*DATA_W-1:0] w_mul_p, w_prod_fin;
  logic [DATA_W:0]     w_shift;
  logic                w_ge;
  logic [DATA_W-1:0]   w_sub, w_div_acc, w_div_q;

  // ALU operation decode
  always_comb begin
    w_alu_op = c_OP_ADD;
    w_shamt  = 1'b0;
    case (i_alu_op)
      c_CLS_ADD: w_alu_op = c_OP_ADD;
      c_CLS_SUB: w_alu_op = c_OP_SUB;
      c_CLS_R: begin
        case (i_funct)
          c_F_ADD, c_F_ADDU, c_F_SUB, c_F_SUBU, c_F_AND, c_F_OR, c_F_NOR,
          c_F_XOR, c_F_SLT, c_F_SLL, c_F_SRL, c_F_SRA, c_F_SLLV, c_F_SRLV,
          c_F_SRAV: w_alu_op = ALU_OP'(i_funct);
          c_F_MULT, c_F_MULTU, c_F_DIV, c_F_DIVU, c_F_MFHI, c_F_MTHI,
          c_F_MFLO, c_F_MTLO: w_alu_op = c_OP_IDLE;
          default: w_alu_op = c_OP_BADR;
        endcase
        w_shamt = (i_funct == c_F_SLL) || (i_funct == c_F_SRL) || (i_funct == c_F_SRA);
      end
      default: begin
        case (i_opcode)
          c_O_SLTI, c_O_ANDI, c_O_ORI, c_O_XORI: w_alu_op = ALU_OP'(i_opcode);
          default: w_alu_op = c_OP_BADI;
        endcase
      end
    endcase
  end

  assign w_rclass = i_valid && (i_alu_op == c_CLS_R);
  assign w_idle   = (r_state == S_IDLE);
  assign w_last   = (r_cnt == c_LAST);
  assign w_start  = w_rclass && w_idle &&
                    ((i_funct == c_F_MULT) || (i_funct == c_F_MULTU) ||
                     (i_funct == c_F_DIV)  || (i_funct == c_F_DIVU));
  assign w_mthi   = w_rclass && w_idle && (i_funct == c_F_MTHI);
  assign w_mtlo   = w_rclass && w_idle && (i_funct == c_F_MTLO);
  assign w_signed = ~i_funct[0];

  // Both units iterate on magnitudes; signs are restored on the final write
  assign w_rs_mag = (w_signed && i_rs_data[DATA_W-1]) ? -i_rs_data : i_rs_data;
  assign w_rt_mag = (w_signed && i_rt_data[DATA_W-1]) ? -i_rt_data : i_rt_data;

  assign w_add      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
  assign w_mul_p    = {w_add, r_q[DATA_W-1:1]};
  assign w_prod_fin = r_neg_q ? -w_mul_p : w_mul_p;

  assign w_shift   = {r_acc, r_q[DATA_W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_sub     = w_shift[DATA_W-1:0] - r_b;
  assign w_div_acc = w_ge ? w_sub : w_shift[DATA_W-1:0];
  assign w_div_q   = {r_q[DATA_W-2:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = i_funct[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= w_rs_mag;
            r_b     <= w_rt_mag;
            r_neg_q <= w_signed && (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
            r_neg_r <= w_signed && i_rs_data[DATA_W-1];
            r_dz    <= (i_rt_data == '0);
          end
          if (w_mthi) r_hi <= i_rs_data;
          if (w_mtlo) r_lo <= i_rs_data;
        end
        S_MUL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          {r_acc, r_q} <= w_mul_p;
          if (w_last) {r_hi, r_lo} <= w_prod_fin;
        end
        S_DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          if (w_last) begin
            // Zero divisor leaves the dividend magnitude in r_acc, so HI needs no special case
            r_lo <= r_dz ? {DATA_W{1'b1}} : (r_neg_q ? -w_div_q : w_div_q);
            r_hi <= r_neg_r ? -w_div_acc : w_div_acc;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alu_op <= '0;
      r_shamt  <= 1'b0;
    end else if (w_idle) begin
      r_alu_op <= w_alu_op;
      r_shamt  <= w_shamt;
    end
  end

  assign o_alu_op    = r_alu_op;
  assign o_shamt     = r_shamt;
  assign o_stall     = ~w_idle;
  assign o_hilo_data = (w_rclass && w_idle && (i_funct == c_F_MFHI)) ? r_hi :
                       (w_rclass && w_idle && (i_funct == c_F_MFLO)) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_control_alu_mdu.sv
`default_nettype none
// ============================================================================
// tb_control_alu_mdu : directed self-checking bench for control_alu_mdu
// Rev 1.0
// ============================================================================
module tb_control_alu_mdu;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic [5:0]  i_funct;
  logic [5:0]  i_opcode;
  logic [1:0]  i_alu_op;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [5:0]  o_alu_op;
  logic        o_shamt;
  logic        o_stall;
  logic [31:0] o_hilo_data;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [5:0] c_MULT = 6'b011000, c_MULTU = 6'b011001;
  localparam logic [5:0] c_DIV  = 6'b011010, c_DIVU  = 6'b011011;
  localparam logic [5:0] c_MFHI = 6'b010000, c_MTHI  = 6'b010001;
  localparam logic [5:0] c_MFLO = 6'b010010, c_MTLO  = 6'b010011;

  control_alu_mdu #(.DATA_W(32), .BITS_ALU(6), .BITS_ALU_CTL(2), .ALU_OP(6)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_funct(i_funct),
    .i_opcode(i_opcode), .i_alu_op(i_alu_op), .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data), .o_alu_op(o_alu_op), .o_shamt(o_shamt),
    .o_stall(o_stall), .o_hilo_data(o_hilo_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic dec(input logic [1:0] cls, input logic [5:0] funct, input logic [5:0] opc,
                     input logic vld, input logic [5:0] exp_op, input logic exp_sh,
                     input string tag);
    i_valid = vld; i_alu_op = cls; i_funct = funct; i_opcode = opc;
    tick();
    check_eq({tag, "_op"}, {26'd0, o_alu_op}, {26'd0, exp_op});
    check_eq({tag, "_sh"}, {31'd0, o_shamt}, {31'd0, exp_sh});
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_stall && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    i_valid = 1'b1; i_alu_op = 2'b10;
    i_funct = c_MFHI; #1;
    check_eq({tag, "_hi"}, o_hilo_data, exp_hi);
    i_funct = c_MFLO; #1;
    check_eq({tag, "_lo"}, o_hilo_data, exp_lo);
    i_valid = 1'b0;
  endtask

  task automatic mdu_op(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n;
    i_valid = 1'b1; i_alu_op = 2'b10; i_funct = funct; i_rs_data = rs; i_rt_data = rt;
    tick();
    i_valid = 1'b0;
    check_eq({tag, "_aluop"}, {26'd0, o_alu_op}, 32'h3F);
    wait_idle(n);
    check_eq({tag, "_stallcyc"}, n, 32);
    read_hilo(exp_hi, exp_lo, tag);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_valid = 1'b0; i_funct = '0; i_opcode = '0; i_alu_op = '0;
    i_rs_data = '0; i_rt_data = '0;
    tick(); tick();
    check_eq("rst_aluop", {26'd0, o_alu_op}, 32'h0);
    check_eq("rst_shamt", {31'd0, o_shamt}, 32'h0);
    check_eq("rst_stall", {31'd0, o_stall}, 32'h0);
    i_reset = 1'b0;
    read_hilo(32'h0, 32'h0, "rst");

    dec(2'b10, 6'b000011, 6'b000000, 1'b1, 6'b000011, 1'b1, "sra");
    dec(2'b11, 6'b000000, 6'b000100, 1'b1, 6'b111101, 1'b0, "beq_imm");
    dec(2'b00, 6'b000011, 6'b000000, 1'b1, 6'b100000, 1'b0, "cls_add");
    dec(2'b01, 6'b000000, 6'b000000, 1'b1, 6'b100010, 1'b0, "cls_sub");
    dec(2'b10, 6'b101010, 6'b000000, 1'b1, 6'b101010, 1'b0, "slt");
    dec(2'b10, 6'b000110, 6'b000000, 1'b1, 6'b000110, 1'b0, "srlv");
    dec(2'b10, 6'b001000, 6'b000000, 1'b1, 6'b111110, 1'b0, "bad_r");
    dec(2'b11, 6'b000000, 6'b001101, 1'b1, 6'b001101, 1'b0, "ori");
    dec(2'b00, 6'b000000, 6'b000000, 1'b0, 6'b100000, 1'b0, "novalid");
    dec(2'b10, c_MULT,    6'b000000, 1'b0, 6'b111111, 1'b0, "mult_nv");
    check_eq("mult_nv_stall", {31'd0, o_stall}, 32'h0);

    mdu_op(c_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    mdu_op(c_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, "multu");
    mdu_op(c_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    mdu_op(c_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negd");
    mdu_op(c_DIVU,  32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, "divu_z");
    mdu_op(c_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_z");
    mdu_op(c_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");

    // MT* while busy must be dropped
    i_valid = 1'b1; i_alu_op = 2'b10; i_funct = c_DIVU; i_rs_data = 32'd100; i_rt_data = 32'd7;
    tick();
    i_funct = c_MTLO; i_rs_data = 32'h12345678;
    tick(); tick();
    i_funct = c_MFLO; #1;
    check_eq("busy_hilo", o_hilo_data, 32'h0);
    i_funct = c_MTLO;
    wait_idle(n);
    i_valid = 1'b0;
    check_eq("busy_done", {31'd0, o_stall}, 32'h0);
    read_hilo(32'd2, 32'd14, "divu_mt");
    i_valid = 1'b1; i_alu_op = 2'b10; i_funct = c_MTLO; i_rs_data = 32'h12345678;
    tick();
    i_funct = c_MTHI; i_rs_data = 32'hCAFEF00D;
    tick();
    read_hilo(32'hCAFEF00D, 32'h12345678, "mt");

    // Reset during a divide aborts it
    i_valid = 1'b1; i_alu_op = 2'b10; i_funct = c_DIV; i_rs_data = 32'd100; i_rt_data = 32'd3;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    check_eq("mid_stall", {31'd0, o_stall}, 32'h1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("abort_stall", {31'd0, o_stall}, 32'h0);
    check_eq("abort_aluop", {26'd0, o_alu_op}, 32'h0);
    read_hilo(32'h0, 32'h0, "abort");
    mdu_op(c_MULT, 32'd5, 32'd6, 32'h0, 32'd30, "mult56");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
